// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: single-pixel read-modify-write and bulk clear of a
// 128x96 1-bpp framebuffer held in SRAM (384 x 32-bit words, 4 per row).
// Optional build macro FB_VSYNC_GATE_EN adds vga_v_active, which holds new
// SRAM strobes off while the display is scanning the visible area.
module fb_pixel_writer #(
  parameter logic [31:0] BASE_ADDR     = 32'd0,
  parameter int unsigned WORDS_PER_ROW = 4,
  parameter int unsigned ROWS          = 96,
  parameter int unsigned FB_WORDS      = ROWS * WORDS_PER_ROW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_x,
  input  logic [6:0]  req_y,
  input  logic [1:0]  req_op,
  input  logic        clear_all,
  output logic        busy,
  output logic        err,
  output logic [31:0] word_address_dest,
  output logic [3:0]  byte_select,
  output logic        SRAM_read_en,
  output logic        SRAM_write_en,
  output logic [31:0] SRAM_data_out,
  input  logic [31:0] SRAM_data_in,
`ifdef FB_VSYNC_GATE_EN
  input  logic        vga_v_active,
`endif
  input  logic        SRAM_busy
);

  localparam int CW = $clog2(FB_WORDS);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_DATA, MODIFY, WR_REQ, CLR_REQ
  } state_t;

  typedef enum logic [1:0] {
    OP_CLR = 2'd0,
    OP_SET = 2'd1,
    OP_TGL = 2'd2,
    OP_NOP = 2'd3
  } op_t;

  state_t        r_state;
  state_t        w_next_state;

  logic [31:0]   r_addr;
  logic [3:0]    r_be;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic [4:0]    r_bit;
  op_t           r_op;
  logic [CW-1:0] r_clr_cnt;

  logic          w_accept;
  logic          w_in_range;
  logic [31:0]   w_req_addr;
  logic          w_strb_allow;
  logic          w_sram_acc;
  logic          w_clr_last;

  // Apply the requested operation to one bit of a framebuffer word.
  function automatic logic [31:0] apply_op(input logic [31:0] word,
                                           input logic [4:0]  bit_idx,
                                           input op_t         op);
    logic [31:0] mask;
    mask = 32'd1 << bit_idx;
    case (op)
      OP_CLR:  apply_op = word & ~mask;
      OP_SET:  apply_op = word | mask;
      OP_TGL:  apply_op = word ^ mask;
      default: apply_op = word;
    endcase
  endfunction

  // Request decode: clear_all wins over a simultaneous pixel request.
  assign w_accept   = (r_state == IDLE) && req_valid && !clear_all && !rst;
  assign w_in_range = (32'(req_y) < ROWS);
  assign w_req_addr = BASE_ADDR + 32'(req_y) * 32'(WORDS_PER_ROW)
                    + 32'(req_x[6:5]);
  assign w_clr_last = (r_clr_cnt == CW'(FB_WORDS - 1));

  assign req_ready  = w_accept;
  assign err        = w_accept && !w_in_range;
  assign busy       = (r_state != IDLE);

`ifdef FB_VSYNC_GATE_EN
  logic r_strb_held;

  // Remember a strobe that is up and still waiting, so a rising
  // vga_v_active cannot pull it back mid-handshake.
  always_ff @(posedge clk) begin
    if (rst) r_strb_held <= 1'b0;
    else     r_strb_held <= (SRAM_read_en || SRAM_write_en) && SRAM_busy;
  end

  assign w_strb_allow = !vga_v_active || r_strb_held;
`else
  assign w_strb_allow = 1'b1;
`endif

  assign SRAM_read_en      = (r_state == RD_REQ) && w_strb_allow;
  assign SRAM_write_en     = ((r_state == WR_REQ) || (r_state == CLR_REQ))
                           && w_strb_allow;
  assign w_sram_acc        = (SRAM_read_en || SRAM_write_en) && !SRAM_busy;
  assign word_address_dest = r_addr;
  assign byte_select       = r_be;
  assign SRAM_data_out     = r_wdata;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: defaulting first keeps every path assigned, so no latch forms.
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (clear_all)                   w_next_state = CLR_REQ;
        else if (w_accept && w_in_range) w_next_state = RD_REQ;
      end
      RD_REQ:  if (w_sram_acc) w_next_state = RD_DATA;
      RD_DATA: w_next_state = MODIFY;
      MODIFY:  w_next_state = WR_REQ;
      WR_REQ:  if (w_sram_acc) w_next_state = IDLE;
      CLR_REQ: if (w_sram_acc && w_clr_last) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: address, lanes, read capture, modified word and clear counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_bit     <= '0;
      r_op      <= OP_NOP;
      r_clr_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (clear_all) begin
            r_addr    <= BASE_ADDR;
            r_be      <= 4'hF;
            r_wdata   <= '0;
            r_clr_cnt <= '0;
          end else if (w_accept && w_in_range) begin
            r_addr <= w_req_addr;
            r_be   <= 4'hF;
            r_bit  <= req_x[4:0];
            r_op   <= op_t'(req_op);
          end
        end
        RD_DATA: r_rdata <= SRAM_data_in;
        MODIFY: begin
          r_wdata <= apply_op(r_rdata, r_bit, r_op);
          r_be    <= 4'b0001 << r_bit[4:3];
        end
        CLR_REQ: begin
          if (w_sram_acc) begin
            r_addr    <= r_addr + 32'd1;
            r_clr_cnt <= w_clr_last ? '0 : r_clr_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Self-checking bench for fb_pixel_writer: table of single-pixel vectors
// against a behavioural SRAM, plus backpressure, bulk clear and reset cases.
module tb_fb_pixel_writer;

  localparam int FBW = 384;

  logic        clk, rst;
  logic        req_valid, req_ready, clear_all, busy, err;
  logic [6:0]  req_x, req_y;
  logic [1:0]  req_op;
  logic [31:0] word_address_dest, SRAM_data_out, SRAM_data_in;
  logic [3:0]  byte_select;
  logic        SRAM_read_en, SRAM_write_en, SRAM_busy;

  fb_pixel_writer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_op(req_op),
    .clear_all(clear_all), .busy(busy), .err(err),
    .word_address_dest(word_address_dest), .byte_select(byte_select),
    .SRAM_read_en(SRAM_read_en), .SRAM_write_en(SRAM_write_en),
    .SRAM_data_out(SRAM_data_out), .SRAM_data_in(SRAM_data_in),
`ifdef FB_VSYNC_GATE_EN
    .vga_v_active(1'b0),
`endif
    .SRAM_busy(SRAM_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural SRAM ----------------
  logic [31:0] mem [0:FBW-1];
  logic [31:0] log_addr [0:1023];
  logic [31:0] log_data [0:1023];
  logic [3:0]  log_be   [0:1023];
  int          cyc = 0, rd_count = 0, wr_count = 0, wr_cyc = 0;
  logic [31:0] rd_addr, wr_addr, wr_data;
  logic [3:0]  rd_be, wr_be;
  logic        pre_all = 1'b0, pre_one = 1'b0;
  logic [8:0]  pre_addr = '0;
  logic [31:0] pre_val = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pre_all) for (int i = 0; i < FBW; i++) mem[i] <= pre_val;
    else if (pre_one) mem[pre_addr] <= pre_val;
    if (SRAM_read_en && !SRAM_busy) begin
      rd_count     <= rd_count + 1;
      rd_addr      <= word_address_dest;
      rd_be        <= byte_select;
      SRAM_data_in <= (word_address_dest < FBW) ? mem[word_address_dest[8:0]]
                                                : 32'hDEAD_BEEF;
    end
    if (SRAM_write_en && !SRAM_busy) begin
      wr_count <= wr_count + 1;
      wr_cyc   <= cyc;
      wr_addr  <= word_address_dest;
      wr_data  <= SRAM_data_out;
      wr_be    <= byte_select;
      log_addr[wr_count[9:0]] <= word_address_dest;
      log_data[wr_count[9:0]] <= SRAM_data_out;
      log_be[wr_count[9:0]]   <= byte_select;
      if (word_address_dest < FBW)
        for (int b = 0; b < 4; b++)
          if (byte_select[b])
            mem[word_address_dest[8:0]][8*b +: 8] <= SRAM_data_out[8*b +: 8];
    end
  end

  // ---------------- checking ----------------
  int n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic preload_all(input logic [31:0] v);
    @(negedge clk); pre_all = 1'b1; pre_val = v;
    @(negedge clk); pre_all = 1'b0;
  endtask

  task automatic preload_one(input logic [8:0] a, input logic [31:0] v);
    @(negedge clk); pre_one = 1'b1; pre_addr = a; pre_val = v;
    @(negedge clk); pre_one = 1'b0;
  endtask

  // Present one request for one cycle; report handshake and write timing.
  task automatic run_pixel(input logic [6:0] x, input logic [6:0] y,
                           input logic [1:0] op, output logic rdy,
                           output logic er, output int lat, output bit done);
    int t0, wr0;
    @(negedge clk);
    req_valid = 1'b1; req_x = x; req_y = y; req_op = op;
    #1;
    rdy = req_ready; er = err; t0 = cyc; wr0 = wr_count;
    @(negedge clk);
    req_valid = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (wr_count != wr0) done = 1'b1;
      else @(negedge clk);
    end
    lat = wr_cyc - t0;
  endtask

  typedef struct {
    logic [6:0]  x, y;
    logic [1:0]  op;
    logic [31:0] init, addr, data;
    logic [3:0]  be;
    logic        exp_err;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic rdy, er;
    int   lat, t0, wr0, rd0, bad;
    bit   done;

    vecs[0] = '{7'd37,  7'd2,   2'd1, 32'h0000_0000, 32'd9,   32'h0000_0020, 4'b0001, 1'b0};
    vecs[1] = '{7'd0,   7'd0,   2'd1, 32'h0000_0000, 32'd0,   32'h0000_0001, 4'b0001, 1'b0};
    vecs[2] = '{7'd100, 7'd50,  2'd0, 32'hFFFF_FFFF, 32'd203, 32'hFFFF_FFEF, 4'b0001, 1'b0};
    vecs[3] = '{7'd72,  7'd10,  2'd2, 32'h0000_0000, 32'd42,  32'h0000_0100, 4'b0010, 1'b0};
    vecs[4] = '{7'd50,  7'd95,  2'd3, 32'h1234_5678, 32'd381, 32'h1234_5678, 4'b0100, 1'b0};
    vecs[5] = '{7'd127, 7'd95,  2'd1, 32'h0000_0000, 32'd383, 32'h8000_0000, 4'b1000, 1'b0};
    vecs[6] = '{7'd5,   7'd96,  2'd1, 32'h0,         32'd0,   32'h0,         4'b0000, 1'b1};
    vecs[7] = '{7'd5,   7'd127, 2'd2, 32'h0,         32'd0,   32'h0,         4'b0000, 1'b1};

    rst = 1'b1; req_valid = 1'b0; req_x = '0; req_y = '0; req_op = '0;
    clear_all = 1'b0; SRAM_busy = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst req_ready", {31'b0, req_ready}, 32'd0);
    check("rst busy",      {31'b0, busy},      32'd0);
    check("rst err",       {31'b0, err},       32'd0);
    check("rst rd_en",     {31'b0, SRAM_read_en},  32'd0);
    check("rst wr_en",     {31'b0, SRAM_write_en}, 32'd0);
    check("rst addr",      word_address_dest,  32'd0);
    check("rst be",        {28'b0, byte_select}, 32'd0);
    check("rst data_out",  SRAM_data_out,      32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle req_ready", {31'b0, req_ready}, 32'd0);

    // Table-driven single-pixel requests.
    for (int v = 0; v < 8; v++) begin
      if (!vecs[v].exp_err) begin
        preload_one(vecs[v].addr[8:0], vecs[v].init);
        rd0 = rd_count;
        run_pixel(vecs[v].x, vecs[v].y, vecs[v].op, rdy, er, lat, done);
        check($sformatf("v%0d ready", v), {31'b0, rdy}, 32'd1);
        check($sformatf("v%0d err", v),   {31'b0, er},  32'd0);
        check($sformatf("v%0d done", v),  {31'b0, done}, 32'd1);
        check($sformatf("v%0d reads", v), rd_count - rd0, 32'd1);
        check($sformatf("v%0d rd_addr", v), rd_addr, vecs[v].addr);
        check($sformatf("v%0d rd_be", v), {28'b0, rd_be}, 32'hF);
        check($sformatf("v%0d wr_addr", v), wr_addr, vecs[v].addr);
        check($sformatf("v%0d wr_data", v), wr_data, vecs[v].data);
        check($sformatf("v%0d wr_be", v), {28'b0, wr_be}, {28'b0, vecs[v].be});
        check($sformatf("v%0d latency", v), lat, 32'd4);
        @(negedge clk);
        check($sformatf("v%0d mem", v), mem[vecs[v].addr[8:0]], vecs[v].data);
        check($sformatf("v%0d busy after", v), {31'b0, busy}, 32'd0);
      end else begin
        rd0 = rd_count; wr0 = wr_count;
        @(negedge clk);
        req_valid = 1'b1; req_x = vecs[v].x; req_y = vecs[v].y; req_op = vecs[v].op;
        #1;
        check($sformatf("v%0d ready", v), {31'b0, req_ready}, 32'd1);
        check($sformatf("v%0d err", v),   {31'b0, err},       32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check($sformatf("v%0d err pulse", v), {31'b0, err}, 32'd0);
        repeat (3) begin
          check($sformatf("v%0d busy", v), {31'b0, busy}, 32'd0);
          @(negedge clk);
        end
        check($sformatf("v%0d no access", v), (rd_count - rd0) + (wr_count - wr0), 32'd0);
      end
    end

    // Toggle under backpressure: strobes must hold address/data while busy.
    preload_one(9'd383, 32'hFFFF_FFFF);
    rd0 = rd_count; wr0 = wr_count;
    @(negedge clk);
    SRAM_busy = 1'b1;
    req_valid = 1'b1; req_x = 7'd127; req_y = 7'd95; req_op = 2'd2;
    #1 check("bp ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) begin
      check("bp rd_en held", {31'b0, SRAM_read_en}, 32'd1);
      check("bp rd addr",    word_address_dest, 32'd383);
      check("bp rd be",      {28'b0, byte_select}, 32'hF);
      @(negedge clk);
    end
    check("bp rd stalled", rd_count - rd0, 32'd0);
    SRAM_busy = 1'b0;
    @(negedge clk);
    SRAM_busy = 1'b1;
    check("bp rd accepted", rd_count - rd0, 32'd1);
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      if (SRAM_write_en) done = 1'b1;
      else @(negedge clk);
    end
    check("bp wr_en seen", {31'b0, done}, 32'd1);
    repeat (3) begin
      check("bp wr_en held", {31'b0, SRAM_write_en}, 32'd1);
      check("bp wr addr",    word_address_dest, 32'd383);
      check("bp wr data",    SRAM_data_out, 32'h7FFF_FFFF);
      check("bp wr be",      {28'b0, byte_select}, 32'b1000);
      @(negedge clk);
    end
    check("bp wr stalled", wr_count - wr0, 32'd0);
    SRAM_busy = 1'b0;
    @(negedge clk);
    check("bp wr accepted", wr_count - wr0, 32'd1);
    check("bp mem", mem[383], 32'h7FFF_FFFF);
    @(negedge clk);
    check("bp wr_en dropped", {31'b0, SRAM_write_en}, 32'd0);

    // Bulk clear with a simultaneous pixel request.
    preload_all(32'hFFFF_FFFF);
    @(negedge clk);
    clear_all = 1'b1; req_valid = 1'b1; req_x = 7'd5; req_y = 7'd5; req_op = 2'd1;
    #1;
    check("clr req not accepted", {31'b0, req_ready}, 32'd0);
    t0 = cyc; wr0 = wr_count; rd0 = rd_count;
    @(negedge clk);
    clear_all = 1'b0; req_valid = 1'b0;
    check("clr busy", {31'b0, busy}, 32'd1);
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      if (!busy) done = 1'b1;
      else @(negedge clk);
    end
    check("clr finished", {31'b0, done}, 32'd1);
    check("clr writes", wr_count - wr0, 32'd384);
    check("clr reads",  rd_count - rd0, 32'd0);
    check("clr duration", wr_cyc - t0, 32'd384);
    bad = 0;
    for (int i = 0; i < FBW; i++) begin
      if (log_addr[(wr0 + i) % 1024] != i || log_data[(wr0 + i) % 1024] != 0 ||
          log_be[(wr0 + i) % 1024] != 4'hF)
        bad++;
    end
    check("clr write sequence", bad, 32'd0);
    bad = 0;
    for (int i = 0; i < FBW; i++) if (mem[i] != 0) bad++;
    check("clr mem zero", bad, 32'd0);

    // Reset in the middle of a bulk clear.
    preload_all(32'hFFFF_FFFF);
    @(negedge clk);
    clear_all = 1'b1;
    @(negedge clk);
    clear_all = 1'b0;
    wr0 = wr_count;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (wr_count - wr0 == 100) done = 1'b1;
      else @(negedge clk);
    end
    check("mid-clr reached 100", {31'b0, done}, 32'd1);
    rst = 1'b1; SRAM_busy = 1'b1;
    @(negedge clk);
    check("mid-clr wr_en low", {31'b0, SRAM_write_en}, 32'd0);
    check("mid-clr busy low",  {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0; SRAM_busy = 1'b0;
    repeat (10) @(negedge clk);
    check("mid-clr no more writes", wr_count - wr0, 32'd100);
    check("mid-clr mem[99]",  mem[99],  32'h0);
    check("mid-clr mem[100]", mem[100], 32'hFFFF_FFFF);
    run_pixel(7'd3, 7'd1, 2'd1, rdy, er, lat, done);
    check("post-rst ready",   {31'b0, rdy}, 32'd1);
    check("post-rst done",    {31'b0, done}, 32'd1);
    check("post-rst wr_addr", wr_addr, 32'd4);
    check("post-rst wr_data", wr_data, 32'h0000_0008);
    check("post-rst wr_be",   {28'b0, wr_be}, 32'b0001);
    check("post-rst latency", lat, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
